// File: rtl/seq_calc_pkg.sv
// Shared types, segment constants and digit decoding for seq_calculator.
package seq_calc_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StConvert
   } state_t;

   typedef enum logic {
      OpAdd = 1'b0,
      OpMul = 1'b1
   } op_t;

   // Active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

   function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
      logic [6:0] seg;
      case (d)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bcd_converter.sv
// Sequential double-dabble: one binary bit per cycle into DIGITS BCD digits.
// ovf is sticky for any carry out of the top digit, i.e. bin >= 10**DIGITS.
module bcd_converter #(
   parameter int MAG_W  = 8,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [MAG_W-1:0]      bin,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   localparam int CNT_W = $clog2(MAG_W + 1);

   logic [MAG_W-1:0]    sr;
   logic [CNT_W-1:0]    cnt;
   logic                running;
   logic [4*DIGITS-1:0] adj;

   always_comb begin
      adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr      <= '0;
         cnt     <= '0;
         running <= 1'b0;
         done    <= 1'b0;
         bcd     <= '0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            sr      <= bin;
            cnt     <= '0;
            running <= 1'b1;
            bcd     <= '0;
            ovf     <= 1'b0;
         end else if (running) begin
            bcd <= {adj[4*DIGITS-2:0], sr[MAG_W-1]};
            ovf <= ovf | adj[4*DIGITS-1];
            sr  <= {sr[MAG_W-2:0], 1'b0};
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(MAG_W - 1)) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/seq_calculator.sv
// Sequential add/multiply calculator with scanned seven-segment output.
// Define SEQ_CALC_ZERO_BLANK_EN to blank leading zeros and float the '-' sign.
module seq_calculator
   import seq_calc_pkg::*;
#(
   parameter int OP_W        = 4,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [OP_W-1:0]   op1,
   input  logic [OP_W-1:0]   op2,
   input  logic              operation,
   input  logic              sign,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [6:0]        segBits,
   output logic [DIGITS-1:0] trigger
);

   localparam int RES_W = 2 * OP_W + 1;
   localparam int MAG_W = 2 * OP_W;
   localparam int CC_W  = $clog2(OP_W + 1);
   localparam int SC_W  = $clog2(REFRESH_DIV + 1);
   localparam int IDX_W = $clog2(DIGITS);

   state_t                   state;
   op_t                      op_q;
   logic                     sign_q;
   logic [OP_W-1:0]          op1_q, op2_q;
   logic                     mul_neg_q;
   logic [MAG_W-1:0]         mcand_q, acc_q;
   logic [OP_W-1:0]          mplier_q;
   logic [CC_W-1:0]          calc_cnt;
   logic                     res_neg_q;
   logic [DIGITS-1:0][6:0]   disp_q, disp_d;
   logic [SC_W-1:0]          scan_cnt;
   logic [IDX_W-1:0]         scan_idx;

   logic                     op1_neg, op2_neg;
   logic [OP_W-1:0]          op1_mag, op2_mag;
   logic [RES_W-1:0]         op1_ext, op2_ext, sum;
   logic                     sum_neg;
   logic [MAG_W-1:0]         sum_mag, acc_next, res_mag;
   logic                     res_neg, calc_last, conv_start;
   logic                     conv_done, conv_ovf, top_nz, ovf_d;
   logic [4*DIGITS-1:0]      conv_bcd;

   // Multiply operates on magnitudes captured at accept time.
   always_comb begin
      op1_neg = sign & op1[OP_W-1];
      op2_neg = sign & op2[OP_W-1];
      op1_mag = op1_neg ? -op1 : op1;
      op2_mag = op2_neg ? -op2 : op2;
   end

   always_comb begin
      op1_ext   = {{(RES_W-OP_W){sign_q & op1_q[OP_W-1]}}, op1_q};
      op2_ext   = {{(RES_W-OP_W){sign_q & op2_q[OP_W-1]}}, op2_q};
      sum       = op1_ext + op2_ext;
      sum_neg   = sum[RES_W-1];
      sum_mag   = sum_neg ? MAG_W'(-sum) : sum[MAG_W-1:0];
      acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
      res_mag   = (op_q == OpMul) ? acc_next : sum_mag;
      // A zero product is shown unsigned even when the operand signs differ.
      res_neg   = (op_q == OpMul) ? (mul_neg_q & (|acc_next)) : sum_neg;
      calc_last = (op_q == OpAdd) || (calc_cnt == CC_W'(OP_W - 1));
      conv_start = (state == StCalc) && calc_last;
   end

   bcd_converter #(
      .MAG_W  (MAG_W),
      .DIGITS (DIGITS)
   ) u_bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (conv_start),
      .bin   (res_mag),
      .done  (conv_done),
      .bcd   (conv_bcd),
      .ovf   (conv_ovf)
   );

`ifdef SEQ_CALC_ZERO_BLANK_EN
   int msd;
`endif

   always_comb begin
      top_nz = |conv_bcd[4*DIGITS-1 -: 4];
      ovf_d  = conv_ovf | (res_neg_q & top_nz);
`ifdef SEQ_CALC_ZERO_BLANK_EN
      msd = 0;
      for (int i = 0; i < DIGITS; i++) begin
         if (conv_bcd[4*i +: 4] != 4'd0) msd = i;
      end
`endif
      for (int i = 0; i < DIGITS; i++) begin
         disp_d[i] = digit_to_seg(conv_bcd[4*i +: 4]);
`ifdef SEQ_CALC_ZERO_BLANK_EN
         if (i > msd) disp_d[i] = SEG_BLANK;
         if (res_neg_q && (i == msd + 1)) disp_d[i] = SEG_MINUS;
`else
         if (res_neg_q && (i == DIGITS - 1)) disp_d[i] = SEG_MINUS;
`endif
         if (ovf_d) disp_d[i] = SEG_MINUS;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= StIdle;
         busy      <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
         disp_q    <= {DIGITS{SEG_ZERO}};
         op_q      <= OpAdd;
         sign_q    <= 1'b0;
         op1_q     <= '0;
         op2_q     <= '0;
         mul_neg_q <= 1'b0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         calc_cnt  <= '0;
         res_neg_q <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  op_q      <= op_t'(operation);
                  sign_q    <= sign;
                  op1_q     <= op1;
                  op2_q     <= op2;
                  mul_neg_q <= op1_neg ^ op2_neg;
                  mcand_q   <= MAG_W'(op1_mag);
                  mplier_q  <= op2_mag;
                  acc_q     <= '0;
                  calc_cnt  <= '0;
                  busy      <= 1'b1;
                  state     <= StCalc;
               end
            end
            StCalc: begin
               acc_q    <= acc_next;
               mcand_q  <= {mcand_q[MAG_W-2:0], 1'b0};
               mplier_q <= mplier_q >> 1;
               calc_cnt <= calc_cnt + CC_W'(1);
               if (calc_last) begin
                  res_neg_q <= res_neg;
                  state     <= StConvert;
               end
            end
            StConvert: begin
               if (conv_done) begin
                  disp_q   <= disp_d;
                  overflow <= ovf_d;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         scan_idx <= '0;
      end else if (scan_cnt == SC_W'(REFRESH_DIV - 1)) begin
         scan_cnt <= '0;
         scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
      end else begin
         scan_cnt <= scan_cnt + SC_W'(1);
      end
   end

   always_comb begin
      trigger = ~(DIGITS'(1) << scan_idx);
      segBits = disp_q[scan_idx];
   end

endmodule

// File: doc/seq_calculator.md
SEQ_CALCULATOR -- requirements
Module: seq_calculator

Interface
REQ-001 Parameter OP_W, default 4, operand width in bits (range 2..16).
REQ-002 Parameter DIGITS, default 4, number of seven-segment digits (range 2..8).
REQ-003 Parameter REFRESH_DIV, default 100000, clk cycles each digit is enabled during scanning (minimum 1).
REQ-004 Derived constants: RES_W = 2*OP_W + 1 (signed result width) and MAG_W = 2*OP_W (magnitude width).
REQ-005 clk  in  1  single clock; all logic is rising-edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  request; sampled only in IDLE.
REQ-008 op1, op2  in  OP_W  operands.
REQ-009 operation  in  1  0 = add, 1 = multiply.
REQ-010 sign  in  1  1 = operands are two's complement; 0 = operands are unsigned.
REQ-011 busy  out  1  high from the cycle after start is accepted until done.
REQ-012 done  out  1  one-cycle pulse when the display value is updated.
REQ-013 overflow  out  1  high when the last result did not fit the display.
REQ-014 segBits  out  7  segment pattern {g,f,e,d,c,b,a}, active-low.
REQ-015 trigger  out  DIGITS  digit enable, active-low one-hot; bit 0 = least significant digit.

Function
REQ-016 FSM states: IDLE, CALC, CONVERT. Transitions: IDLE->CALC on start; CALC->CONVERT when the arithmetic completes; CONVERT->IDLE after MAG_W conversion steps.
REQ-017 On start in IDLE: op1, op2, operation and sign are registered in the same cycle; later input changes do not affect the operation in flight.
REQ-018 start while busy is ignored and is not queued.
REQ-019 Add takes 1 CALC cycle. The operands are sign- or zero-extended to RES_W bits before the addition.
REQ-020 Multiply takes OP_W CALC cycles using shift-add on the operand magnitudes. The result sign is the XOR of the operand signs when sign=1, and positive otherwise.
REQ-021 CONVERT performs a sequential double-dabble conversion of the result magnitude, one bit per cycle, over MAG_W cycles.
REQ-022 Latency: if start is accepted at edge k, done is high in cycle k+1+C+MAG_W, where C = 1 for add and C = OP_W for multiply. busy falls in the same cycle done is high.
REQ-023 The display registers update only in the done cycle. The previous value stays on the display while busy.
REQ-024 A negative result shows '-' (segment g only) in the most significant digit; the remaining DIGITS-1 digits show the magnitude.
REQ-025 Overflow: if the magnitude needs more digits than are available (DIGITS, or DIGITS-1 when the result is negative), every digit shows '-' and overflow=1. overflow is cleared by the next non-overflowing result.
REQ-026 Scanning: a free-running counter enables each digit for REFRESH_DIV cycles, in the order 0,1,...,DIGITS-1, then wraps to 0. Scanning is independent of the FSM.
REQ-027 Exactly one trigger bit is low at any time after reset.

Reset
REQ-028 rst_n=0 at any edge (including mid-CALC or mid-CONVERT) forces: state IDLE, busy=0, done=0, overflow=0, all display digits set to 0, scan index 0, scan counter 0, trigger = all ones except bit 0 low, segBits = pattern for '0' (7'b1000000).

Configuration
REQ-029 Macro SEQ_CALC_ZERO_BLANK_EN. When defined: leading zeros are blanked (7'b1111111), the '-' is placed immediately left of the most significant nonzero digit, and a result of 0 shows a single '0' in digit 0. When undefined: all digits show numerals, and '-' occupies digit DIGITS-1.

Structure
REQ-030 Package seq_calc_pkg contains: the state enum; the operation encoding; segment constants SEG_MINUS=7'b0111111 and SEG_BLANK=7'b1111111; and a digit-to-segment function covering 0-9.
REQ-031 Sub-module bcd_converter (sequential double dabble, start/done handshake, parametrised by MAG_W and DIGITS); all other logic is inline.

Verification (OP_W=4, DIGITS=4, REFRESH_DIV=4)
REQ-032 Unsigned add 9+7 -> done at k+10; display "0016" (blanking macro: "  16"); overflow=0.
REQ-033 Unsigned multiply 15*15 -> done at k+13; display "0225".
REQ-034 Signed multiply op1=4'b1000 (-8), op2=4'b0111 (7) -> display "-056" (blanking macro: " -56"); signed add 4'b1111+4'b1111 -> "-002".
REQ-035 start pulsed again 3 cycles after an accepted start with different operands -> ignored; the first result is shown; only one done pulse occurs.
REQ-036 rst_n low during CONVERT -> on the next cycle busy=0, the display shows zeros, no done pulse; a subsequent start completes normally.
REQ-037 After reset, trigger sequence is 1110, 1101, 1011, 0111, repeating, with each value held for exactly 4 cycles; segBits matches the digit currently enabled.
